// File: rtl/fsm_input_debounce.sv
// Debounces an asynchronous input: two-flop synchronizer followed by a
// run-length FSM that accepts a new level after DEBOUNCE_CYCLES equal samples.
module fsm_input_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       raw_in,
  input  logic       enable,
  output logic       A,
  output logic       a_rise,
  output logic       a_fall,
  output logic [7:0] glitch_count
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GLITCH_MAX = '1;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHECK_HI  = 2'd1,
    STABLE_HI = 2'd2,
    CHECK_LO  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_q, a_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] glitch_q, glitch_d;

  // State, synchronizer and registered outputs; the synchronizer ignores enable.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      state_q  <= STABLE_LO;
      cnt_q    <= '0;
      a_q      <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      sync1_q  <= raw_in;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  // Next-state: a run of opposite samples either reaches LAST and flips A,
  // or is broken early and counts as one rejected glitch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = glitch_q;
    if (enable) begin
      unique case (state_q)
        STABLE_LO: begin
          if (sync2_q) begin
            if (LAST == '0) begin
              state_d = STABLE_HI;
              a_d     = 1'b1;
              rise_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d = CHECK_HI;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        CHECK_HI: begin
          if (sync2_q) begin
            if (cnt_q == LAST) begin
              state_d = STABLE_HI;
              a_d     = 1'b1;
              rise_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = STABLE_LO;
            cnt_d   = '0;
            if (glitch_q != GLITCH_MAX) glitch_d = glitch_q + CNT_W'(1);
          end
        end
        STABLE_HI: begin
          if (!sync2_q) begin
            if (LAST == '0) begin
              state_d = STABLE_LO;
              a_d     = 1'b0;
              fall_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d = CHECK_LO;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        CHECK_LO: begin
          if (!sync2_q) begin
            if (cnt_q == LAST) begin
              state_d = STABLE_LO;
              a_d     = 1'b0;
              fall_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = STABLE_HI;
            cnt_d   = '0;
            if (glitch_q != GLITCH_MAX) glitch_d = glitch_q + CNT_W'(1);
          end
        end
        default: state_d = STABLE_LO;
      endcase
    end
  end

  assign A            = a_q;
  assign a_rise       = rise_q;
  assign a_fall       = fall_q;
  assign glitch_count = glitch_q;

endmodule
